// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types, status codes and sizing helper for the memory access unit
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_MEM_ERR = 2'b01;
    localparam logic [1:0] STAT_TIMEOUT = 2'b10;
    localparam logic [1:0] STAT_RANGE   = 2'b11;

    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - saturating wait-cycle counter with expiry flag
module mem_timeout_counter #(
    parameter int timeout = 15,
    parameter int cw      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [cw-1:0] count_o,
    output logic          expired_o
);

    localparam logic [cw-1:0] LIMIT = cw'(timeout);

    logic [cw-1:0] count_q;
    logic [cw-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store initiator with range check and timeout
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int width      = 16,
    parameter int addr_width = 4,
    parameter int mem_depth  = 1 << addr_width,
    parameter int timeout    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [addr_width-1:0] req_addr,
    input  logic [width-1:0]      req_wdata,
    output logic [addr_width-1:0] mem_addr,
    output logic                  mem_we,
    output logic [width-1:0]      mem_wdata,
    input  logic [width-1:0]      mem_rdata,
    input  logic                  mem_ready,
    input  logic                  mem_error,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [width-1:0]      resp_rdata,
    output logic [1:0]            resp_status
);

    localparam int CW = cnt_width(timeout);
    // Leaving on the last counted cycle puts resp_valid exactly timeout cycles after the first WAIT sample.
    localparam logic [CW-1:0] LAST_WAIT = CW'(timeout - 1);

    state_e                  state_q, state_d;
    logic [addr_width-1:0]   addr_q, addr_d;
    logic [width-1:0]        wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic [width-1:0]        rdata_q, rdata_d;
    logic [1:0]              status_q, status_d;
    logic [CW-1:0]           cnt;
    logic                    cnt_expired;
    logic                    in_range;
    logic [31:0]             addr_ext;

    assign addr_ext = 32'(req_addr);
    assign in_range = addr_ext < 32'(mem_depth);

    mem_timeout_counter #(
        .timeout (timeout),
        .cw      (CW)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q == ST_SETTLE),
        .en_i      ((state_q == ST_WAIT) && !mem_ready),
        .count_o   (cnt),
        .expired_o (cnt_expired)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!in_range) begin
                        we_d     = 1'b0;
                        rdata_d  = '0;
                        status_d = STAT_RANGE;
                        state_d  = ST_RESP;
                    end else begin
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        we_d    = req_we;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_ready) begin
                    status_d = mem_error ? STAT_MEM_ERR : STAT_OK;
                    rdata_d  = (!we_q && !mem_error) ? mem_rdata : '0;
                    state_d  = ST_RESP;
                end else if ((cnt == LAST_WAIT) || cnt_expired) begin
                    status_d = STAT_TIMEOUT;
                    rdata_d  = '0;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            status_q <= STAT_OK;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign resp_valid  = (state_q == ST_RESP);
    assign mem_we      = we_q && ((state_q == ST_SETTLE) || (state_q == ST_WAIT));
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign resp_rdata  = rdata_q;
    assign resp_status = status_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

CPU-side initiator for the memory ready/error handshake. Accepts one load/store request at a time from the core, drives address, write-enable and write data onto the memory port, and waits for the memory side to signal ready. It then returns read data and a status code to the core. It also checks address range locally and bounds every access with a timeout.

## Interface
Parameters:
- width, 16, data word width
- addr_width, 4, address bus width
- mem_depth, 1 << addr_width, number of valid words; addresses >= mem_depth are out of range
- timeout, 15, maximum WAIT cycles before aborting; must be >= 1

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  core presents a request
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_addr  in  addr_width  request address
- req_wdata  in  width  store data
- mem_addr  out  addr_width  address to memory; held stable across the access
- mem_we  out  1  write strobe to memory
- mem_wdata  out  width  write data to memory
- mem_rdata  in  width  read data from memory
- mem_ready  in  1  memory-side ready
- mem_error  in  1  memory-side error flag, qualified by mem_ready
- resp_valid  out  1  response available
- resp_ready  in  1  core accepts response
- resp_rdata  out  width  load data (0 for stores and failed accesses)
- resp_status  out  2  00 OK, 01 MEM_ERR, 10 TIMEOUT, 11 RANGE

## Operation
- States: IDLE, SETTLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch the request.
  - If req_addr >= mem_depth: go to RESP with status RANGE. No memory access is made, and mem_addr is left unchanged.
  - Otherwise: drive mem_addr/mem_wdata, set mem_we = req_we, and go to SETTLE.
- SETTLE: lasts exactly one cycle. mem_ready is ignored, because memory drops ready in the cycle after an address change. Timeout counter is cleared. Next state is WAIT.
- WAIT:
  - If mem_ready is sampled 1, capture mem_rdata (loads only) and the status (mem_error ? MEM_ERR : OK). Go to RESP.
  - Otherwise the counter increments. When the counter reaches timeout, go to RESP with status TIMEOUT.
  - If mem_ready and timeout occur in the same cycle, mem_ready wins.
- RESP:
  - resp_valid = 1, and resp_rdata/resp_status are held.
  - When resp_ready = 1, go to IDLE.
  - mem_we = 0.
- mem_we is 1 only in SETTLE/WAIT, and only for stores.
- mem_addr and mem_wdata keep their last values in IDLE/RESP, so the memory sees no spurious address change.
- An identical back-to-back address still passes through SETTLE.
- Reset values: req_ready 1 (IDLE), mem_addr 0, mem_we 0, mem_wdata 0, resp_valid 0, resp_rdata 0, resp_status 00, counter 0.
- Reset mid-access: state returns to IDLE on that edge, mem_we drops, and the pending response is discarded.
- The counter is $clog2(timeout+1) bits wide and saturates; it never wraps.

## Timing
- Accept edge = cycle 0. SETTLE = cycle 1. First WAIT sample = cycle 2.
- If ready is sampled at cycle 2, resp_valid is high at cycle 3. Minimum latency is therefore 3 cycles.
- RANGE response: resp_valid is high at cycle 1.
- TIMEOUT response: resp_valid is high at cycle 2 + timeout.
- The unit is one access deep. The next req_ready is seen in the cycle after the resp handshake. Peak throughput is one access per 4 cycles.
- All outputs are registered or decoded from state; there are no combinational paths from mem_* inputs to resp_* outputs.

## Structure
- Package mem_access_pkg holds:
  - the state enum (IDLE, SETTLE, WAIT, RESP);
  - the status constants STAT_OK, STAT_MEM_ERR, STAT_TIMEOUT, STAT_RANGE;
  - a function for the timeout-counter width.
- One sub-module, mem_timeout_counter: synchronous clear, enable, saturating, with an expired flag when count == timeout.
- The FSM, request latch and response registers live in mem_access_unit.

## Test plan
- Load with fast memory: req addr=3, mem_ready high from cycle 2, mem_rdata=16'hBEEF → resp_valid at cycle 3, resp_rdata=16'hBEEF, status 00.
- Store with memory error: req_we=1, addr=5, wdata=16'h1234, mem_ready+mem_error at cycle 4 → mem_we=1 in cycles 1–4, resp status 01, resp_rdata 0.
- Timeout: timeout=15, mem_ready held 0 → status 10 at cycle 17, mem_we deasserts at cycle 17.
- Range: mem_depth=12, addr=13 → status 11 at cycle 1, mem_addr unchanged, mem_we never 1.
- Backpressure plus back-to-back: resp_ready held 0 for 5 cycles → resp held stable, req_ready stays 0. A second request to the same address still sees one SETTLE cycle where mem_ready is ignored.
- Reset mid-WAIT: rst_n low at cycle 2 → next cycle shows the IDLE reset values, no resp_valid, and a fresh request completes normally.
